keypad_timer_entry: RTL and testbench



---
 rtl/microwave_pkg.sv | 16 +
 rtl/bcd_mmss_dec.sv | 41 ++++
 rtl/keypad_timer_entry.sv | 192 +++++++++++++++++++
 tb/tb_keypad_timer_entry.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared constants for the microwave keypad/display path.
// FSM encodings, key indices and BCD limits used by the entry timer.
package microwave_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StEntry = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam int unsigned KEY_START  = 10;
    localparam int unsigned KEY_CANCEL = 11;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] BCD_MAX      = 4'd9;

endpackage

// File: rtl/bcd_mmss_dec.sv
// Combinational MM:SS BCD decrement by one second.
// 00:00 is held rather than wrapped so digits stay in BCD range.
module bcd_mmss_dec
    import microwave_pkg::*;
(
    input  logic [3:0] dig1_i,
    input  logic [3:0] dig2_i,
    input  logic [3:0] dig3_i,
    input  logic [3:0] dig4_i,
    output logic [3:0] nxt1_o,
    output logic [3:0] nxt2_o,
    output logic [3:0] nxt3_o,
    output logic [3:0] nxt4_o,
    output logic       is_zero_next_o
);

    always_comb begin
        nxt1_o = dig1_i;
        nxt2_o = dig2_i;
        nxt3_o = dig3_i;
        nxt4_o = dig4_i;
        if (dig1_i != 4'd0) begin
            nxt1_o = dig1_i - 4'd1;
        end else if (dig2_i != 4'd0) begin
            nxt1_o = BCD_MAX;
            nxt2_o = dig2_i - 4'd1;
        end else if (dig3_i != 4'd0) begin
            nxt1_o = BCD_MAX;
            nxt2_o = SEC_TENS_MAX;
            nxt3_o = dig3_i - 4'd1;
        end else if (dig4_i != 4'd0) begin
            nxt1_o = BCD_MAX;
            nxt2_o = SEC_TENS_MAX;
            nxt3_o = BCD_MAX;
            nxt4_o = dig4_i - 4'd1;
        end
    end

    assign is_zero_next_o = ({nxt4_o, nxt3_o, nxt2_o, nxt1_o} == 16'h0000);

endmodule

// File: rtl/keypad_timer_entry.sv
// Keypad entry of a 4-digit MM:SS cook time and 1 s countdown.
// Feeds BCD digits and enables to the display converters; reports running/done.
module keypad_timer_entry
    import microwave_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [3:0]  dig4,
    output logic [3:0]  en,
    output logic        running,
    output logic        done
);

    localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TickW-1:0]  TickLast  = TickW'(TICK_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    logic [1:0]        state_q, state_d;
    logic [11:0]       key_q;
    logic [3:0]        dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;
    logic [2:0]        count_q, count_d;
    logic [TickW-1:0]  tick_q, tick_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic              phase_q, phase_d;
    logic              done_q, done_d;

    logic [11:0] press;
    logic        digit_hit;
    logic [3:0]  digit_val;
    logic        start_ok;
    logic [3:0]  nxt1, nxt2, nxt3, nxt4;
    logic        is_zero_next;

    bcd_mmss_dec u_dec (
        .dig1_i         (dig1_q),
        .dig2_i         (dig2_q),
        .dig3_i         (dig3_q),
        .dig4_i         (dig4_q),
        .nxt1_o         (nxt1),
        .nxt2_o         (nxt2),
        .nxt3_o         (nxt3),
        .nxt4_o         (nxt4),
        .is_zero_next_o (is_zero_next)
    );

    always_comb begin
        press     = key & ~key_q;
        digit_hit = |press[9:0];
        digit_val = 4'd0;
        // Scan downward so the lowest pressed digit wins.
        for (int i = 9; i >= 0; i--) begin
            if (press[i]) digit_val = 4'(i);
        end
        start_ok = (dig2_q <= SEC_TENS_MAX) && ({dig4_q, dig3_q, dig2_q, dig1_q} != 16'h0000);
    end

    always_comb begin
        state_d = state_q;
        dig1_d  = dig1_q;
        dig2_d  = dig2_q;
        dig3_d  = dig3_q;
        dig4_d  = dig4_q;
        count_d = count_q;
        tick_d  = tick_q;
        blink_d = blink_q;
        phase_d = phase_q;
        done_d  = 1'b0;

        if (press[KEY_CANCEL]) begin
            state_d = StIdle;
            dig1_d  = 4'd0;
            dig2_d  = 4'd0;
            dig3_d  = 4'd0;
            dig4_d  = 4'd0;
            count_d = 3'd0;
            tick_d  = '0;
            blink_d = '0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (digit_hit) begin
                        dig1_d  = digit_val;
                        dig2_d  = 4'd0;
                        dig3_d  = 4'd0;
                        dig4_d  = 4'd0;
                        count_d = 3'd1;
                        state_d = StEntry;
                    end
                end
                StEntry: begin
                    // A start press, even a rejected one, shadows a same-cycle digit.
                    if (press[KEY_START]) begin
                        if (start_ok) begin
                            state_d = StRun;
                            tick_d  = '0;
                        end
                    end else if (digit_hit && (count_q < 3'd4)) begin
                        dig4_d  = dig3_q;
                        dig3_d  = dig2_q;
                        dig2_d  = dig1_q;
                        dig1_d  = digit_val;
                        count_d = count_q + 3'd1;
                    end
                end
                StRun: begin
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        dig1_d = nxt1;
                        dig2_d = nxt2;
                        dig3_d = nxt3;
                        dig4_d = nxt4;
                        if (is_zero_next) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            blink_d = '0;
                            phase_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TickW'(1);
                    end
                end
                StDone: begin
                    if (press[KEY_START] || digit_hit) begin
                        state_d = StIdle;
                        count_d = 3'd0;
                        blink_d = '0;
                        phase_d = 1'b0;
                    end else if (blink_q == BlinkLast) begin
                        blink_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        blink_d = blink_q + BlinkW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= 12'h000;
            dig1_q  <= 4'd0;
            dig2_q  <= 4'd0;
            dig3_q  <= 4'd0;
            dig4_q  <= 4'd0;
            count_q <= 3'd0;
            tick_q  <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
            dig3_q  <= dig3_d;
            dig4_q  <= dig4_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        case (state_q)
            StEntry, StRun: en = 4'b1111;
            StDone:         en = phase_q ? 4'b0000 : 4'b1111;
            default:        en = 4'b0000;
        endcase
    end

    assign dig1    = dig1_q;
    assign dig2    = dig2_q;
    assign dig3    = dig3_q;
    assign dig4    = dig4_q;
    assign running = (state_q == StRun);
    assign done    = done_q;

endmodule

// File: tb/tb_keypad_timer_entry.sv
// Bench for keypad_timer_entry: directed plan plus random key traffic,
// every cycle compared against a seconds-based reference model.
module tb_keypad_timer_entry;

    localparam int TICK  = 4;
    localparam int BLINK = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ENTRY = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] key = 12'h000;
    logic [3:0]  dig1, dig2, dig3, dig4, en;
    logic        running, done;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_state;
    logic [3:0]  m_d [1:4];
    int          m_cnt;
    int          m_run_cyc;
    int          m_done_cyc;
    logic        m_done;
    logic [11:0] m_kprev;

    keypad_timer_entry #(
        .TICK_DIV  (TICK),
        .BLINK_DIV (BLINK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .dig1    (dig1),
        .dig2    (dig2),
        .dig3    (dig3),
        .dig4    (dig4),
        .en      (en),
        .running (running),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = M_IDLE;
        for (int i = 1; i <= 4; i++) m_d[i] = 4'd0;
        m_cnt      = 0;
        m_run_cyc  = 0;
        m_done_cyc = 0;
        m_done     = 1'b0;
        m_kprev    = 12'h000;
    endtask

    task automatic model_edge(input logic r, input logic [11:0] k);
        logic [11:0] p;
        int          n;
        int          secs;
        if (r) begin
            model_reset();
            return;
        end
        p       = k & ~m_kprev;
        m_kprev = k;
        m_done  = 1'b0;
        n = -1;
        for (int i = 9; i >= 0; i--) if (p[i]) n = i;
        if (p[11]) begin
            m_state = M_IDLE;
            for (int i = 1; i <= 4; i++) m_d[i] = 4'd0;
            m_cnt = 0;
        end else begin
            case (m_state)
                M_IDLE: if (n >= 0) begin
                    m_d[4] = 0; m_d[3] = 0; m_d[2] = 0; m_d[1] = 4'(n);
                    m_cnt = 1;
                    m_state = M_ENTRY;
                end
                M_ENTRY: begin
                    if (p[10]) begin
                        if (m_d[2] <= 4'd5 && {m_d[4], m_d[3], m_d[2], m_d[1]} != 16'h0) begin
                            m_state   = M_RUN;
                            m_run_cyc = 0;
                        end
                    end else if (n >= 0 && m_cnt < 4) begin
                        m_d[4] = m_d[3]; m_d[3] = m_d[2]; m_d[2] = m_d[1]; m_d[1] = 4'(n);
                        m_cnt++;
                    end
                end
                M_RUN: begin
                    m_run_cyc++;
                    if (m_run_cyc % TICK == 0) begin
                        secs = (m_d[4] * 10 + m_d[3]) * 60 + m_d[2] * 10 + m_d[1] - 1;
                        m_d[4] = 4'((secs / 60) / 10);
                        m_d[3] = 4'((secs / 60) % 10);
                        m_d[2] = 4'((secs % 60) / 10);
                        m_d[1] = 4'((secs % 60) % 10);
                        if (secs == 0) begin
                            m_state    = M_DONE;
                            m_done     = 1'b1;
                            m_done_cyc = 0;
                        end
                    end
                end
                default: begin
                    if (p[10] || n >= 0) begin
                        m_state = M_IDLE;
                        m_cnt   = 0;
                    end else begin
                        m_done_cyc++;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [3:0] model_en();
        case (m_state)
            M_ENTRY, M_RUN: return 4'b1111;
            M_DONE:         return ((m_done_cyc / BLINK) % 2 == 0) ? 4'b1111 : 4'b0000;
            default:        return 4'b0000;
        endcase
    endfunction

    // Apply inputs for one cycle, advance the model, compare all outputs.
    task automatic step(input logic r, input logic [11:0] k);
        rst = r;
        key = k;
        @(posedge clk);
        #1;
        model_edge(r, k);
        cmp("dig1", {12'h0, dig1}, {12'h0, m_d[1]});
        cmp("dig2", {12'h0, dig2}, {12'h0, m_d[2]});
        cmp("dig3", {12'h0, dig3}, {12'h0, m_d[3]});
        cmp("dig4", {12'h0, dig4}, {12'h0, m_d[4]});
        cmp("en", {12'h0, en}, {12'h0, model_en()});
        cmp("running", {15'h0, running}, {15'h0, (m_state == M_RUN)});
        cmp("done", {15'h0, done}, {15'h0, m_done});
    endtask

    task automatic press_key(input int n);
        step(1'b0, 12'(1 << n));
        step(1'b0, 12'h000);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        press_key(a);
        press_key(b);
        press_key(c);
        press_key(d);
    endtask

    logic [11:0] rk;
    int unsigned sel;

    initial begin
        model_reset();
        step(1'b1, 12'h000);
        step(1'b1, 12'h000);
        cmp("reset_digits", {dig4, dig3, dig2, dig1}, 16'h0000);
        cmp("reset_en", {12'h0, en}, 16'h0000);
        cmp("reset_flags", {14'h0, running, done}, 16'h0000);

        enter4(1, 2, 3, 4);
        cmp("entry_1234", {dig4, dig3, dig2, dig1}, 16'h1234);
        cmp("entry_en", {12'h0, en}, 16'h000f);
        press_key(5);
        cmp("fifth_digit_ignored", {dig4, dig3, dig2, dig1}, 16'h1234);
        press_key(11);

        enter4(0, 0, 0, 2);
        press_key(10);
        cmp("run_started", {15'h0, running}, 16'h0001);
        idle(3);
        cmp("after_one_tick", {dig4, dig3, dig2, dig1}, 16'h0001);
        idle(4);
        cmp("reached_zero", {dig4, dig3, dig2, dig1}, 16'h0000);
        cmp("done_pulse", {14'h0, running, done}, 16'h0001);
        idle(1);
        cmp("done_one_cycle", {15'h0, done}, 16'h0000);
        idle(1);
        cmp("blink_off", {12'h0, en}, 16'h0000);
        idle(2);
        cmp("blink_on", {12'h0, en}, 16'h000f);
        press_key(11);

        enter4(0, 1, 0, 0);
        press_key(10);
        idle(3);
        cmp("borrow_minute", {dig4, dig3, dig2, dig1}, 16'h0059);
        press_key(11);
        enter4(1, 0, 0, 0);
        press_key(10);
        idle(3);
        cmp("borrow_ten_min", {dig4, dig3, dig2, dig1}, 16'h0959);
        press_key(11);

        enter4(0, 0, 7, 0);
        press_key(10);
        cmp("bad_start_rejected", {15'h0, running}, 16'h0000);
        cmp("bad_start_digits", {dig4, dig3, dig2, dig1}, 16'h0070);
        press_key(11);
        press_key(10);
        cmp("idle_start_ignored", {dig4, dig3, dig2, dig1}, 16'h0000);

        press_key(1);
        step(1'b0, 12'hc00);
        cmp("cancel_beats_start", {dig4, dig3, dig2, dig1}, 16'h0000);
        cmp("cancel_en", {12'h0, en}, 16'h0000);
        step(1'b0, 12'h000);

        press_key(5);
        press_key(10);
        idle(2);
        step(1'b0, 12'h800);
        cmp("cancel_mid_run", {14'h0, running, done}, 16'h0000);
        step(1'b0, 12'h000);

        press_key(1);
        for (int i = 0; i < 10; i++) step(1'b0, 12'h008);
        step(1'b0, 12'h000);
        cmp("held_key_once", {dig4, dig3, dig2, dig1}, 16'h0013);

        press_key(9);
        press_key(10);
        idle(1);
        step(1'b1, 12'h000);
        cmp("rst_mid_run", {dig4, dig3, dig2, dig1, en}, 20'h0);
        cmp("rst_mid_run_flags", {14'h0, running, done}, 16'h0000);
        step(1'b0, 12'h000);

        rk = 12'h000;
        for (int c = 0; c < 4000; c++) begin
            sel = $urandom_range(0, 99);
            if (sel < 30) rk = 12'h000;
            else if (sel < 40) rk = 12'(1 << $urandom_range(0, 11));
            else if (sel < 42) rk = 12'($urandom);
            step(($urandom_range(0, 799) == 0), rk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
